stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//  One-to-N routing counterpart of the 2:1 mux: one valid/ready input stream, N output streams.
//  Each input beat carries a destination index; the beat is buffered and presented only to that destination.
//  Used in miniRISC to fan one producer out to N consumers:
//   - writeback results to register/IO sinks;
//   - store data to memory-mapped slaves.
//  Order is preserved across all destinations (single FIFO, head-of-line blocking by design).
// PARAMETERS
//  W   16  data width of each beat
//  N   4   number of destinations (2..16)
//  SW  2   select width; must equal clog2(N)
// PORTS
//  CLK        in   1     clock, all logic on rising edge
//  RST_N      in   1     synchronous active-low reset
//  IN_VALID   in   1     input beat valid
//  IN_READY   out  1     block can accept a beat this cycle
//  IN_SEL     in   SW    destination index of input beat
//  IN_DATA    in   W     input beat payload
//  OUT_VALID  out  N     one-hot; bit k = head beat is for destination k
//  OUT_READY  in   N     per-destination ready
//  OUT_DATA   out  W     head beat payload, shared by all destinations
//  ERR        out  1     one-cycle pulse: a beat with IN_SEL >= N was dropped
//  DROP_CNT   out  8     saturating count of dropped beats
// BEHAVIOUR
//  - Reset: one clock, synchronous, RST_N low at the rising edge.
//    Next state: occupancy EMPTY, OUT_VALID=0, OUT_DATA=0, ERR=0, DROP_CNT=0.
//    IN_READY=0 while RST_N is low.
//    Reset mid-operation discards all buffered beats and does not count them as drops.
//  - Storage: 2-entry FIFO (skid). Occupancy states EMPTY / ONE / TWO.
//  - IN_READY = RST_N && (state != TWO). No combinational path from OUT_READY to IN_READY.
//  - accept = IN_VALID && IN_READY.
//    Beat with IN_SEL < N is pushed.
//    Beat with IN_SEL >= N is consumed but not stored:
//      ERR=1 in the next cycle only;
//      DROP_CNT += 1, saturating at 255.
//    Only possible when N is not a power of two.
//  - Head presentation, when state != EMPTY:
//      OUT_VALID = onehot(head_sel), OUT_DATA = head_data.
//    When EMPTY: OUT_VALID=0, OUT_DATA=0.
//  - pop = |(OUT_VALID & OUT_READY). Readies of non-selected destinations are ignored.
//  - Latency: beat accepted at edge t is presented after edge t (1 cycle) when the FIFO was EMPTY.
//  - Transitions (push = accept of a valid-index beat):
//      EMPTY: push -> ONE; else stay.
//      ONE:   push&pop -> ONE, new beat becomes head; push -> TWO; pop -> EMPTY; else stay.
//      TWO:   pop -> ONE, second entry becomes head; else stay. No push possible.
//  - Throughput: 1 beat/cycle sustained when the head destination is always ready.
//  - Head stability: OUT_VALID/OUT_DATA stay stable until popped (AXI-style); head_sel never changes under a stalled head.
//  - Dropped beats never occupy a slot and never block; a drop may coincide with a pop.
// STRUCTURE
//  - Shared package miniRISC_pkg gets:
//      occupancy encodings EMPTY=2'b00, ONE=2'b01, TWO=2'b10;
//      DROP_CNT_MAX=8'hFF.
//  - One sub-module: skid_buf2 (W+SW-bit, 2-entry FIFO with push/pop/occupancy).
//  - Top holds: select decode to one-hot, range check, ERR/DROP_CNT registers.
// TESTING
//  - Reset: drive RST_N=0 for 2 cycles with IN_VALID=1.
//    -> IN_READY=0, OUT_VALID=0, OUT_DATA=0, DROP_CNT=0, and no beat stored.
//  - Single route: with N=4, send SEL=2, DATA=16'hA5A5; all OUT_READY=1.
//    -> next cycle OUT_VALID=4'b0100, OUT_DATA=A5A5; popped the same cycle.
//  - Backpressure: OUT_READY=0, send 3 beats.
//    -> 2 accepted, then IN_READY=0.
//    -> Raise OUT_READY: beats emerge in order, 1/cycle, and IN_READY returns to 1 after the first pop.
//  - Head-of-line blocking: beat to dst1 with OUT_READY[1]=0, then beat to dst3 with OUT_READY[3]=1.
//    -> dst3 beat is not presented until dst1 is popped.
//  - Bad select: with N=3, send SEL=3 twice with a full FIFO draining.
//    -> ERR pulses 1 cycle each, DROP_CNT=2, no OUT_VALID for them.
//    -> 300 drops give DROP_CNT=255.
//  - Mid-operation reset: with the FIFO at TWO, pulse RST_N low 1 cycle.
//    -> next cycle EMPTY, OUT_VALID=0, IN_READY=1, and the buffered beats never appear.

Source files
------------

// File: rtl/miniRISC_pkg.sv
// Shared miniRISC definitions used by the stream demux.
// Holds the FIFO occupancy encoding and the drop-counter limit.
package miniRISC_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } occ_t;

    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO (skid buffer): head slot is always the oldest beat.
// Push and pop in the same cycle from ONE replaces the head in place.
module skid_buf2
    import miniRISC_pkg::*;
#(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output occ_t          occ
);

    occ_t            state;
    occ_t            state_nxt;
    logic [DW-1:0]   head_q;
    logic [DW-1:0]   head_nxt;
    logic [DW-1:0]   tail_q;
    logic [DW-1:0]   tail_nxt;

    always_comb begin
        state_nxt = state;
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_nxt  = din;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_nxt = din;
                end else if (push) begin
                    state_nxt = TWO;
                    tail_nxt  = din;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                // no push possible here: upstream ready is low when full
                if (pop) begin
                    state_nxt = ONE;
                    head_nxt  = tail_q;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            state  <= state_nxt;
            head_q <= head_nxt;
            tail_q <= tail_nxt;
        end
    end

    assign head = head_q;
    assign occ  = state;

endmodule

// File: rtl/stream_demux.sv
// One-to-N stream router: each beat goes only to its destination, in order.
// Out-of-range selects are consumed, flagged on err and counted.
module stream_demux
    import miniRISC_pkg::*;
#(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_sel,
    input  logic [W-1:0]  in_data,
    output logic [N-1:0]  out_valid,
    input  logic [N-1:0]  out_ready,
    output logic [W-1:0]  out_data,
    output logic          err,
    output logic [7:0]    drop_cnt
);

    localparam logic [SW:0] N_LIM = (SW + 1)'(N);

    occ_t              occ;
    logic [W+SW-1:0]   buf_head;
    logic [SW-1:0]     head_sel;
    logic [W-1:0]      head_data;
    logic              head_valid;
    logic [N-1:0]      sel_oh;
    logic              in_range;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;

    // ready depends only on registered occupancy, never on out_ready
    assign in_ready = rst_n && (occ != TWO);
    assign accept   = in_valid && in_ready;
    assign in_range = {1'b0, in_sel} < N_LIM;
    assign push     = accept && in_range;
    assign drop     = accept && !in_range;

    skid_buf2 #(
        .DW(W + SW)
    ) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  ({in_sel, in_data}),
        .head (buf_head),
        .occ  (occ)
    );

    assign head_sel   = buf_head[W+SW-1:W];
    assign head_data  = buf_head[W-1:0];
    assign head_valid = (occ != EMPTY);

    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < N; k++) begin
            sel_oh[k] = (head_sel == SW'(k));
        end
    end

    assign out_valid = head_valid ? sel_oh : '0;
    assign out_data  = head_valid ? head_data : '0;
    assign pop       = |(out_valid & out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err      <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            err <= drop;
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: N=4 routing table plus N=3 drop sequences.
module tb_stream_demux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [15:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
    logic        err;
    logic [7:0]  drop_cnt;

    // N=3 instance
    logic        rst3;
    logic        v3;
    logic        ir3;
    logic [1:0]  sel3;
    logic [15:0] d3;
    logic [2:0]  ov3;
    logic [2:0]  rdy3;
    logic [15:0] od3;
    logic        err3;
    logic [7:0]  cnt3;

    stream_demux #(.W(16), .N(4), .SW(2)) u4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err      (err),
        .drop_cnt (drop_cnt)
    );

    stream_demux #(.W(16), .N(3), .SW(2)) u3 (
        .clk      (clk),
        .rst_n    (rst3),
        .in_valid (v3),
        .in_ready (ir3),
        .in_sel   (sel3),
        .in_data  (d3),
        .out_valid(ov3),
        .out_ready(rdy3),
        .out_data (od3),
        .err      (err3),
        .drop_cnt (cnt3)
    );

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [1:0]  sel;
        logic [15:0] d;
        logic [3:0]  rdy;
        logic        e_ir;
        logic [3:0]  e_ov;
        logic [15:0] e_od;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic v, input logic [1:0] s,
                       input logic [15:0] d, input logic [3:0] rdy,
                       input logic ir, input logic [3:0] ov,
                       input logic [15:0] od);
        vec_t x;
        x.rst_n = r;  x.v = v;  x.sel = s;  x.d = d;  x.rdy = rdy;
        x.e_ir = ir;  x.e_ov = ov;  x.e_od = od;
        x.e_err = 1'b0;  x.e_cnt = 8'd0;
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive3(input logic v, input logic [1:0] s,
                          input logic [15:0] d, input logic [2:0] r);
        @(posedge clk);
        #1;
        v3 = v;  sel3 = s;  d3 = d;  rdy3 = r;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;  in_valid = 1'b1;  in_sel = 2'd1;
        in_data = 16'h1111;  out_ready = 4'hF;
        rst3 = 1'b0;  v3 = 1'b0;  sel3 = 2'd0;  d3 = 16'h0;  rdy3 = 3'b0;

        //   rst v  sel  data      rdy      ir  ov       od
        add(0, 1, 1, 16'h1111, 4'hF,    0, 4'b0000, 16'h0000);
        add(1, 1, 2, 16'hA5A5, 4'hF,    1, 4'b0000, 16'h0000);
        add(1, 0, 0, 16'h0000, 4'hF,    1, 4'b0100, 16'hA5A5);
        add(1, 1, 0, 16'h1000, 4'h0,    1, 4'b0000, 16'h0000);
        add(1, 1, 1, 16'h2001, 4'h0,    1, 4'b0001, 16'h1000);
        add(1, 1, 3, 16'h3003, 4'h0,    0, 4'b0001, 16'h1000);
        add(1, 1, 3, 16'h3003, 4'hF,    0, 4'b0001, 16'h1000);
        add(1, 1, 3, 16'h3003, 4'hF,    1, 4'b0010, 16'h2001);
        add(1, 0, 0, 16'h0000, 4'hF,    1, 4'b1000, 16'h3003);
        add(1, 1, 1, 16'h4444, 4'b1000, 1, 4'b0000, 16'h0000);
        add(1, 1, 3, 16'h5555, 4'b1000, 1, 4'b0010, 16'h4444);
        add(1, 0, 0, 16'h0000, 4'b1000, 0, 4'b0010, 16'h4444);
        add(1, 0, 0, 16'h0000, 4'b1010, 0, 4'b0010, 16'h4444);
        add(1, 0, 0, 16'h0000, 4'b1000, 1, 4'b1000, 16'h5555);
        add(1, 1, 0, 16'h6666, 4'h0,    1, 4'b0000, 16'h0000);
        add(1, 1, 2, 16'h7777, 4'h0,    1, 4'b0001, 16'h6666);
        add(0, 0, 0, 16'h0000, 4'h0,    0, 4'b0001, 16'h6666);
        add(1, 0, 0, 16'h0000, 4'hF,    1, 4'b0000, 16'h0000);
        add(1, 0, 0, 16'h0000, 4'hF,    1, 4'b0000, 16'h0000);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            rst_n = tbl[i].rst_n;  in_valid = tbl[i].v;
            in_sel = tbl[i].sel;  in_data = tbl[i].d;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            check($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].e_err));
            check($sformatf("row%0d drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].e_cnt));
        end

        // N=3: drops of sel=3 while a full FIFO drains
        drive3(1'b0, 2'd0, 16'h0, 3'b000);
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        @(negedge clk);
        check("n3 reset cnt", 32'(cnt3), 32'd0);
        check("n3 reset ov", 32'(ov3), 32'd0);
        drive3(1'b1, 2'd0, 16'h00AA, 3'b000);
        drive3(1'b1, 2'd1, 16'h00BB, 3'b000);
        drive3(1'b1, 2'd3, 16'hDEAD, 3'b111);
        check("n3 full ready", 32'(ir3), 32'd0);
        check("n3 head0 ov", 32'(ov3), 32'b001);
        check("n3 head0 data", 32'(od3), 32'h00AA);
        drive3(1'b1, 2'd3, 16'hDEAD, 3'b111);
        check("n3 ready after pop", 32'(ir3), 32'd1);
        check("n3 head1 ov", 32'(ov3), 32'b010);
        check("n3 head1 data", 32'(od3), 32'h00BB);
        check("n3 no err yet", 32'(err3), 32'd0);
        drive3(1'b1, 2'd3, 16'hBEEF, 3'b111);
        check("n3 err pulse1", 32'(err3), 32'd1);
        check("n3 cnt1", 32'(cnt3), 32'd1);
        check("n3 drop ov1", 32'(ov3), 32'd0);
        drive3(1'b0, 2'd0, 16'h0, 3'b111);
        check("n3 err pulse2", 32'(err3), 32'd1);
        check("n3 cnt2", 32'(cnt3), 32'd2);
        check("n3 drop ov2", 32'(ov3), 32'd0);
        drive3(1'b0, 2'd0, 16'h0, 3'b111);
        check("n3 err clear", 32'(err3), 32'd0);
        check("n3 cnt hold", 32'(cnt3), 32'd2);

        for (int k = 0; k < 300; k++) begin
            drive3(1'b1, 2'd3, 16'(k), 3'b111);
        end
        drive3(1'b0, 2'd0, 16'h0, 3'b111);
        check("n3 cnt sat", 32'(cnt3), 32'd255);
        check("n3 sat ov", 32'(ov3), 32'd0);
        drive3(1'b0, 2'd0, 16'h0, 3'b111);
        check("n3 err after sat", 32'(err3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
